// File: rtl/ysyx_25040111_ifu_fetch.sv
// Instruction-fetch responder: turns a pc/pc_valid pulse into one AXI4-Lite
// read and hands the instruction to decode over a valid/ready handshake,
// flagging misaligned PCs, bus errors and bus timeouts as fetch faults.
//
// state | meaning
// IDLE  | waiting for a pc_valid pulse
// ADDR  | arvalid high, waiting for arready
// DATA  | rready high, waiting for rvalid
// HOLD  | inst_valid high, waiting for decode to take the instruction
module ysyx_25040111_ifu_fetch #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              fetch_fault
);

  // The counter only needs to reach TIMEOUT-1: the stalled cycle that finds
  // it there is the TIMEOUT-th one and triggers the fault.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             aligned;
  logic             take_pc;
  logic             stall;
  logic             to_fire;

  assign aligned = (pc[1:0] == 2'b00);
  // A new PC is taken in IDLE, or in HOLD when decode accepts in the same cycle.
  assign take_pc = pc_valid && ((state_q == IDLE) || ((state_q == HOLD) && inst_ready));
  assign stall   = ((state_q == ADDR) && !arready) || ((state_q == DATA) && !rvalid);
  assign to_fire = TO_EN && stall && (cnt_q == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (take_pc) state_d = aligned ? ADDR : HOLD;
      ADDR: begin
        if (arready)      state_d = DATA;
        else if (to_fire) state_d = HOLD;
      end
      DATA: if (rvalid || to_fire) state_d = HOLD;
      HOLD: begin
        if (take_pc)         state_d = aligned ? ADDR : HOLD;
        else if (inst_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall counter: cleared on entry to ADDR/DATA, advances on every stalled cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if ((state_d != state_q) && ((state_d == ADDR) || (state_d == DATA))) begin
      cnt_q <= '0;
    end else if (stall) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered outputs; a taken PC is applied last so it wins over the HOLD release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      case (state_q)
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end else if (to_fire) begin
            arvalid     <= 1'b0;
            inst        <= '0;
            fetch_fault <= 1'b1;
            inst_valid  <= 1'b1;
          end
        end
        DATA: begin
          if (rvalid) begin
            rready     <= 1'b0;
            inst_valid <= 1'b1;
            if (rresp == 2'b00) begin
              inst        <= rdata;
              fetch_fault <= 1'b0;
            end else begin
              inst        <= '0;
              fetch_fault <= 1'b1;
            end
          end else if (to_fire) begin
            rready      <= 1'b0;
            inst        <= '0;
            fetch_fault <= 1'b1;
            inst_valid  <= 1'b1;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b0;
          end
        end
        default: ;
      endcase
      if (take_pc) begin
        inst_pc <= pc;
        if (aligned) begin
          araddr  <= pc;
          arvalid <= 1'b1;
        end else begin
          inst        <= '0;
          fetch_fault <= 1'b1;
          inst_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_ifu_fetch.sv
// Bench for ysyx_25040111_ifu_fetch: directed fetch scenarios with a
// scoreboard of expected instructions/addresses and per-cycle protocol rules.
module tb_ysyx_25040111_ifu_fetch;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        busy;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic [31:0] exp_addr[$];
  exp_t        exp_inst[$];

  always #5 clk = ~clk;

  ysyx_25040111_ifu_fetch #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .busy(busy),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .fetch_fault(fetch_fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle rules: phase/busy consistency, stability under backpressure,
  // and every new address / instruction matched against the scoreboard.
  logic        p_arv = 1'b0, p_arr = 1'b0, p_rr = 1'b0, p_rv = 1'b0;
  logic        p_iv = 1'b0, p_ir = 1'b0, p_f = 1'b0;
  logic [31:0] p_araddr = '0, p_inst = '0, p_ipc = '0;
  exp_t        e;
  logic [31:0] ea;

  always @(negedge clk) begin
    if (!reset) begin
      p_arv = 1'b0; p_rr = 1'b0; p_iv = 1'b0;
    end else begin
      chk1("busy_vs_phase", busy, arvalid | rready | inst_valid);
      chk1("single_phase", $countones({arvalid, rready, inst_valid}) <= 1, 1'b1);
      if (!inst_valid) chk1("fault_without_valid", fetch_fault, 1'b0);
      if (p_arv && !p_arr) begin
        if (arvalid) chk("araddr_stable", araddr, p_araddr);
        else         chk1("ar_drop_is_timeout", inst_valid && fetch_fault, 1'b1);
      end
      if (p_rr && !p_rv && !rready) chk1("r_drop_is_timeout", inst_valid && fetch_fault, 1'b1);
      if (p_rr && p_rv) chk1("resp_gives_inst", inst_valid, 1'b1);
      if (p_iv && !p_ir) begin
        chk1("hold_valid", inst_valid, 1'b1);
        chk("hold_inst", inst, p_inst);
        chk("hold_inst_pc", inst_pc, p_ipc);
        chk1("hold_fault", fetch_fault, p_f);
      end else if (inst_valid) begin
        if (exp_inst.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_inst: got inst_valid at pc 0x%08h, expected none", inst_pc);
        end else begin
          e = exp_inst.pop_front();
          chk("sb_inst", inst, e.inst);
          chk("sb_inst_pc", inst_pc, e.pc);
          chk1("sb_fault", fetch_fault, e.fault);
        end
      end
      if (arvalid && !(p_arv && !p_arr)) begin
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ar: got araddr 0x%08h, expected no request", araddr);
        end else begin
          ea = exp_addr.pop_front();
          chk("sb_araddr", araddr, ea);
        end
      end
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
      p_rr = rready; p_rv = rvalid;
      p_iv = inst_valid; p_ir = inst_ready; p_inst = inst; p_ipc = inst_pc; p_f = fetch_fault;
    end
  end

  // One aligned fetch with given bus stalls, response and decode hold time.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                          input int ar_wait, input int r_wait, input int hold,
                          input bit b2b, input bit leave);
    exp_t x;
    x.inst  = (resp == 2'b00) ? d : 32'h0;
    x.pc    = a;
    x.fault = (resp != 2'b00);
    exp_addr.push_back(a);
    exp_inst.push_back(x);
    pc = a; pc_valid = 1'b1; inst_ready = b2b; arready = (ar_wait == 0);
    tick;
    pc_valid = 1'b0; inst_ready = 1'b0;
    chk1("launch_arvalid", arvalid, 1'b1);
    chk("launch_araddr", araddr, a);
    chk1("launch_no_inst", inst_valid, 1'b0);
    for (int i = 0; i < ar_wait; i++) begin
      arready = 1'b0;
      chk1("ar_wait_arvalid", arvalid, 1'b1);
      tick;
    end
    arready = 1'b1;
    tick;
    arready = 1'b0;
    chk1("data_rready", rready, 1'b1);
    chk1("data_arvalid_low", arvalid, 1'b0);
    for (int i = 0; i < r_wait; i++) begin
      rvalid = 1'b0;
      chk1("r_wait_rready", rready, 1'b1);
      chk1("r_wait_no_inst", inst_valid, 1'b0);
      tick;
    end
    rvalid = 1'b1; rdata = d; rresp = resp;
    tick;
    rvalid = 1'b0; rresp = 2'b00;
    chk1("resp_inst_valid", inst_valid, 1'b1);
    chk1("resp_fault", fetch_fault, x.fault);
    chk("resp_inst", inst, x.inst);
    chk1("resp_rready_low", rready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      chk1("hold_inst_valid", inst_valid, 1'b1);
      tick;
    end
    if (!leave) begin
      inst_ready = 1'b1;
      tick;
      inst_ready = 1'b0;
      chk1("accept_valid_low", inst_valid, 1'b0);
      chk1("accept_idle", busy, 1'b0);
    end
  endtask

  exp_t x;

  initial begin
    reset = 1'b0; pc = '0; pc_valid = 1'b0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rvalid = 1'b0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk1("rst_fault", fetch_fault, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    reset = 1'b1;
    tick;

    // Minimum-latency fetch with arready already high.
    do_fetch(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 0, 1'b0, 1'b0);
    // Stalled address and data phases.
    do_fetch(32'h8000_0010, 32'h00c5_8533, 2'b00, 5, 3, 0, 1'b0, 1'b0);
    // SLVERR, held by decode for two cycles, then a clean fetch.
    do_fetch(32'h8000_0020, 32'h1234_5678, 2'b10, 0, 1, 2, 1'b0, 1'b0);
    do_fetch(32'h8000_0024, 32'h0010_0073, 2'b00, 1, 0, 0, 1'b0, 1'b0);

    // Misaligned PC: fault straight to decode, no bus request.
    x.inst = 32'h0; x.pc = 32'h8000_0002; x.fault = 1'b1;
    exp_inst.push_back(x);
    pc = 32'h8000_0002; pc_valid = 1'b1;
    tick;
    pc_valid = 1'b0;
    chk1("mis_inst_valid", inst_valid, 1'b1);
    chk1("mis_fault", fetch_fault, 1'b1);
    chk("mis_inst_pc", inst_pc, 32'h8000_0002);
    chk("mis_inst", inst, 32'h0);
    chk1("mis_no_arvalid", arvalid, 1'b0);
    repeat (2) begin
      tick;
      chk1("mis_hold_no_arvalid", arvalid, 1'b0);
    end
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    chk1("mis_done_idle", busy, 1'b0);

    // Decode backpressure for 4 cycles, then accept plus new PC together.
    do_fetch(32'h8000_0030, 32'h0000_0297, 2'b00, 0, 0, 4, 1'b0, 1'b1);
    do_fetch(32'h8000_0004, 32'h0002_8067, 2'b00, 1, 1, 0, 1'b1, 1'b0);

    // Reset while DATA is waiting and rvalid is pending.
    exp_addr.push_back(32'h8000_0040);
    pc = 32'h8000_0040; pc_valid = 1'b1; arready = 1'b1;
    tick;
    pc_valid = 1'b0;
    tick;
    arready = 1'b0;
    chk1("rst_mid_pre_rready", rready, 1'b1);
    rvalid = 1'b1; rdata = 32'hCAFE_F00D; reset = 1'b0;
    #1;
    chk1("rst_mid_rready", rready, 1'b0);
    chk1("rst_mid_arvalid", arvalid, 1'b0);
    chk1("rst_mid_inst_valid", inst_valid, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_fault", fetch_fault, 1'b0);
    chk("rst_mid_araddr", araddr, 32'h0);
    chk("rst_mid_inst_pc", inst_pc, 32'h0);
    tick;
    reset = 1'b1;
    tick;
    rvalid = 1'b0;
    chk1("rst_after_no_inst", inst_valid, 1'b0);
    chk1("rst_after_idle", busy, 1'b0);

    // Timeout in DATA: rready high for exactly TO cycles, then a fault.
    exp_addr.push_back(32'h8000_0050);
    x.inst = 32'h0; x.pc = 32'h8000_0050; x.fault = 1'b1;
    exp_inst.push_back(x);
    pc = 32'h8000_0050; pc_valid = 1'b1; arready = 1'b1;
    tick;
    pc_valid = 1'b0;
    tick;
    arready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk1("to_r_rready", rready, 1'b1);
      chk1("to_r_no_inst", inst_valid, 1'b0);
      tick;
    end
    chk1("to_r_inst_valid", inst_valid, 1'b1);
    chk1("to_r_fault", fetch_fault, 1'b1);
    chk1("to_r_rready_low", rready, 1'b0);
    chk("to_r_inst", inst, 32'h0);
    rvalid = 1'b1; rdata = 32'h0BAD_0BAD;
    tick;
    rvalid = 1'b0;
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    chk1("to_r_done_idle", busy, 1'b0);
    tick;
    chk1("to_r_stray_ignored", inst_valid, 1'b0);

    // Timeout in ADDR: arvalid high for exactly TO cycles.
    exp_addr.push_back(32'h8000_0060);
    x.inst = 32'h0; x.pc = 32'h8000_0060; x.fault = 1'b1;
    exp_inst.push_back(x);
    pc = 32'h8000_0060; pc_valid = 1'b1; arready = 1'b0;
    tick;
    pc_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk1("to_ar_arvalid", arvalid, 1'b1);
      tick;
    end
    chk1("to_ar_arvalid_low", arvalid, 1'b0);
    chk1("to_ar_inst_valid", inst_valid, 1'b1);
    chk1("to_ar_fault", fetch_fault, 1'b1);
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;

    // Recovery: a clean fetch after the faults.
    do_fetch(32'h8000_0070, 32'h0000_0013, 2'b00, 2, 2, 1, 1'b0, 1'b0);

    tick;
    chk("exp_inst_drained", 32'(exp_inst.size()), 32'h0);
    chk("exp_addr_drained", 32'(exp_addr.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
